// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Included by the address decoder, the responder top and its testbench.
package dmem_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10,
    CAUSE_BOTH     = 2'b11
  } err_cause_t;

  localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h1001_0000;
  localparam int          DMEM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU load/store port: the CPU is the master, the data memory is the slave.
interface dmem_responder_if;

  logic        rena;
  logic        wena;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rena, output wena, output addr, output wdata, input rdata);
  modport slave  (input rena, input wena, input addr, input wdata, output rdata);

endinterface

// File: rtl/dmem_addr_decode.sv
// Combinational address decode for the data memory: word index, range and
// alignment checks, and the fault cause with priority both > misaligned > range.
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DMEM_BASE_DEFAULT,
  parameter int          DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             rena,
  input  logic             wena,
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             in_range,
  output logic             aligned,
  output err_cause_t       cause
);

  // Compare in 33 bits so the byte size of the array never overflows.
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] offset;

  assign offset   = addr - ADDR_BASE;
  assign in_range = {1'b0, offset} < RANGE_BYTES;
  assign aligned  = (addr[1:0] == 2'b00);
  assign idx      = offset[IDX_W+1:2];

  always_comb begin
    cause = CAUSE_NONE;
    if (rena || wena) begin
      if (rena && wena)   cause = CAUSE_BOTH;
      else if (!aligned)  cause = CAUSE_MISALIGN;
      else if (!in_range) cause = CAUSE_RANGE;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data memory serving the CPU load/store port: combinational reads, clocked
// writes, sticky first-fault record. Optional counters under DMEM_STATS_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DMEM_BASE_DEFAULT,
  parameter int          DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              err,
  output logic [31:0]       err_addr,
  output err_cause_t        err_cause
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             aligned;
  err_cause_t       cause;
  logic             fault;
  logic             valid_read;
  logic             valid_write;

  dmem_addr_decode #(
    .ADDR_BASE   (ADDR_BASE),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_decode (
    .rena     (bus.rena),
    .wena     (bus.wena),
    .addr     (bus.addr),
    .idx      (idx),
    .in_range (in_range),
    .aligned  (aligned),
    .cause    (cause)
  );

  assign fault       = (cause != CAUSE_NONE);
  assign valid_read  = bus.rena && !bus.wena && !fault;
  assign valid_write = bus.wena && !bus.rena && !fault;

  // Reset gates the read path too, so rdata drops the moment rst goes low.
  assign bus.rdata = (valid_read && rst) ? mem[idx] : '0;

  // Array contents deliberately survive reset; only the write is gated by it.
  always_ff @(posedge clk) begin
    if (rst && valid_write) begin
      mem[idx] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err       <= 1'b0;
      err_addr  <= '0;
      err_cause <= CAUSE_NONE;
    end else if (fault && !err) begin
      err       <= 1'b1;
      err_addr  <= bus.addr;
      err_cause <= cause;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (valid_read && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      if (valid_write && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios then randomized
// traffic, all compared against a word-array model of the memory.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        err;
  logic [31:0] err_addr;
  err_cause_t  err_cause;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err       (err),
    .err_addr  (err_addr),
    .err_cause (err_cause)
`ifdef DMEM_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  logic [31:0] m_mem [DEPTH];
  logic        m_err;
  logic [31:0] m_err_addr;
  logic [1:0]  m_err_cause;
  logic [31:0] m_rd;
  logic [31:0] m_wr;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Fault cause straight from the access rules.
  function automatic logic [1:0] ref_cause(input logic r, input logic w, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (!(r || w))            return 2'b00;
    if (r && w)               return 2'b11;
    if (a % 4 != 0)           return 2'b01;
    if (off >= 32'(DEPTH * 4)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int ref_word(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_record();
    check_output("err", {31'b0, err}, {31'b0, m_err});
    check_output("err_addr", err_addr, m_err_addr);
    check_output("err_cause", {30'b0, err_cause}, {30'b0, m_err_cause});
`ifdef DMEM_STATS_EN
    check_output("rd_count", rd_count, m_rd);
    check_output("wr_count", wr_count, m_wr);
`endif
  endtask

  // One access cycle: drive, check the combinational read, clock, check state.
  task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [1:0]  c;
    logic [31:0] exp_rd;
    @(negedge clk);
    bus.rena = r; bus.wena = w; bus.addr = a; bus.wdata = d;
    #1;
    c = ref_cause(r, w, a);
    exp_rd = (r && !w && c == 2'b00) ? m_mem[ref_word(a)] : 32'h0;
    check_output("rdata", bus.rdata, exp_rd);
    @(posedge clk);
    if (c != 2'b00 && !m_err) begin
      m_err = 1'b1; m_err_addr = a; m_err_cause = c;
    end
    if (c == 2'b00 && w && !r) m_mem[ref_word(a)] = d;
    if (c == 2'b00 && r && !w && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
    if (c == 2'b00 && w && !r && m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
    #1;
    check_record();
  endtask

  // Assert reset between edges while an access is on the bus.
  task automatic reset_mid_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.rena = r; bus.wena = w; bus.addr = a; bus.wdata = d;
    #1;
    rst = 1'b0;
    m_err = 1'b0; m_err_addr = '0; m_err_cause = 2'b00; m_rd = '0; m_wr = '0;
    #1;
    check_output("rst_rdata", bus.rdata, 32'h0);
    check_record();
    @(posedge clk);
    #1;
    check_record();
    @(negedge clk);
    bus.rena = 1'b0; bus.wena = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        r;
    logic        w;
    int          kind;
    int          op;

    rst = 1'b0;
    bus.rena = 1'b0; bus.wena = 1'b0; bus.addr = '0; bus.wdata = '0;
    m_err = 1'b0; m_err_addr = '0; m_err_cause = 2'b00; m_rd = '0; m_wr = '0;
    #7;
    check_record();
    check_output("reset_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b1, BASE + 32'(i * 4), $urandom);
    reset_mid_access(1'b0, 1'b0, 32'h0, 32'h0);

    // Store then load.
    apply_stimulus(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
    apply_stimulus(1'b1, 1'b0, 32'h1001_0008, 32'h0);
    check_output("store_load", bus.rdata, 32'hDEAD_BEEF);
    check_output("store_load_err", {31'b0, err}, 32'h0);

    // Misaligned store leaves the neighbouring word alone.
    d = m_mem[1];
    apply_stimulus(1'b0, 1'b1, 32'h1001_0006, 32'h1234_5678);
    check_output("misalign_err", {31'b0, err}, 32'h1);
    check_output("misalign_addr", err_addr, 32'h1001_0006);
    check_output("misalign_cause", {30'b0, err_cause}, 32'h1);
    apply_stimulus(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    check_output("misalign_word", bus.rdata, d);

    // Reset during a store: the store is blocked, earlier data survives.
    d = m_mem[4];
    reset_mid_access(1'b0, 1'b1, 32'h1001_0010, 32'hCAFE_F00D);
    apply_stimulus(1'b1, 1'b0, 32'h1001_0008, 32'h0);
    check_output("survive_reset", bus.rdata, 32'hDEAD_BEEF);
    apply_stimulus(1'b1, 1'b0, 32'h1001_0010, 32'h0);
    check_output("blocked_store", bus.rdata, d);
    reset_mid_access(1'b1, 1'b0, 32'h1001_0008, 32'h0);

    // Out of range, then a below-base fault that must not overwrite the record.
    apply_stimulus(1'b1, 1'b0, 32'h1001_1000, 32'h0);
    check_output("range_cause", {30'b0, err_cause}, 32'h2);
    apply_stimulus(1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0);
    check_output("sticky_addr", err_addr, 32'h1001_1000);
    check_output("sticky_cause", {30'b0, err_cause}, 32'h2);
    reset_mid_access(1'b0, 1'b0, 32'h0, 32'h0);

    // Both requests at once.
    d = m_mem[0];
    apply_stimulus(1'b1, 1'b1, 32'h1001_0000, 32'h1);
    check_output("both_cause", {30'b0, err_cause}, 32'h3);
    apply_stimulus(1'b1, 1'b0, 32'h1001_0000, 32'h0);
    check_output("both_word", bus.rdata, d);
    reset_mid_access(1'b0, 1'b0, 32'h0, 32'h0);

`ifdef DMEM_STATS_EN
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, BASE + 32'(i * 4), 32'h0);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b1, BASE + 32'(i * 4), $urandom);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h2, 32'h0);
    check_output("stats_rd", rd_count, 32'd3);
    check_output("stats_wr", wr_count, 32'd2);
    @(negedge clk);
    force dut.rd_count = 32'hFFFF_FFFF;
    #1;
    release dut.rd_count;
    m_rd = 32'hFFFF_FFFF;
    apply_stimulus(1'b1, 1'b0, BASE, 32'h0);
    check_output("stats_sat", rd_count, 32'hFFFF_FFFF);
    reset_mid_access(1'b0, 1'b0, 32'h0, 32'h0);
`endif

    // Randomized traffic; periodic resets re-arm the sticky record.
    for (int n = 0; n < 400; n++) begin
      if (n % 40 == 39) begin
        reset_mid_access(1'($urandom), 1'($urandom), BASE + 32'($urandom_range(0, DEPTH - 1) * 4), $urandom);
        continue;
      end
      kind = $urandom_range(0, 9);
      a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      if (kind == 6) a = a + 32'($urandom_range(1, 3));
      else if (kind == 7) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
      else if (kind == 8) a = BASE - 32'($urandom_range(1, 64) * 4);
      else if (kind == 9) a = $urandom;
      op = $urandom_range(0, 9);
      r = (op <= 3) || (op == 8);
      w = (op >= 4 && op <= 8);
      apply_stimulus(r, w, a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
